// File: rtl/pipelined_cla_pkg.sv
// Shared sizing constants, the pipeline stage record and the depth helper
// for the pipelined carry-lookahead adder.
package pipelined_cla_pkg;

    localparam int DEFAULT_SLICE_W = 4;
    localparam int MAX_WIDTH       = 64;

    // Fields are sized for the widest legal adder; narrower instances use the low bits.
    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic                 c_top;
        logic [MAX_WIDTH-1:0] sum;
        logic [MAX_WIDTH-1:0] a;
        logic [MAX_WIDTH-1:0] b;
    } stage_rec_t;

    function automatic int stages_of(input int width, input int slice_w);
        return width / slice_w;
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_slice.sv
// Combinational SLICE_W-bit carry-lookahead slice; also exposes the carry
// into its top bit so the last slice can drive signed overflow.
module cla_slice
    import pipelined_cla_pkg::*;
#(
    parameter int SLICE_W = DEFAULT_SLICE_W
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co,
    output logic               c_top
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W:0]   c;
    logic               term;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is a flat OR of generate terms qualified by the propagates above them.
    always_comb begin
        c    = '0;
        term = 1'b0;
        c[0] = ci;
        for (int i = 0; i < SLICE_W; i++) begin
            term = ci;
            for (int m = 0; m <= i; m++) term = term & p[m];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) term = term & p[m];
                c[i+1] = c[i+1] | term;
            end
        end
    end

    assign s     = p ^ c[SLICE_W-1:0];
    assign co    = c[SLICE_W];
    assign c_top = c[SLICE_W-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor: an operand capture register followed by one
// lookahead slice per stage, all advancing together unless the output stalls.
module pipelined_cla_adder
    import pipelined_cla_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SLICE_W = DEFAULT_SLICE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = stages_of(WIDTH, SLICE_W);

    stage_rec_t         rec_q [STAGES+1];
    stage_rec_t         rec_d [STAGES+1];
    logic [SLICE_W-1:0] slice_s  [STAGES];
    logic               slice_co [STAGES];
    logic               slice_ct [STAGES];
    logic               stall;
    logic               unused_tail;

    assign out_valid = rec_q[STAGES].valid;
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_slice
            cla_slice #(.SLICE_W(SLICE_W)) u_slice (
                .a     (rec_q[k].a[k*SLICE_W +: SLICE_W]),
                .b     (rec_q[k].b[k*SLICE_W +: SLICE_W]),
                .ci    (rec_q[k].carry),
                .s     (slice_s[k]),
                .co    (slice_co[k]),
                .c_top (slice_ct[k])
            );
        end
    endgenerate

    // Record 0 captures the effective operands; record k+1 is record k with slice k completed.
    always_comb begin
        rec_d[0]              = '0;
        rec_d[0].valid        = in_valid;
        rec_d[0].a[WIDTH-1:0] = a;
        rec_d[0].b[WIDTH-1:0] = sub ? ~b : b;
        rec_d[0].carry        = sub | cin;
        for (int i = 0; i < STAGES; i++) begin
            rec_d[i+1]                              = rec_q[i];
            rec_d[i+1].sum[i*SLICE_W +: SLICE_W]    = slice_s[i];
            rec_d[i+1].carry                        = slice_co[i];
            rec_d[i+1].c_top                        = slice_ct[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= STAGES; i++) rec_q[i] <= '0;
        end else if (!stall) begin
            for (int i = 0; i <= STAGES; i++) rec_q[i] <= rec_d[i];
        end
    end

    assign sum  = rec_q[STAGES].sum[WIDTH-1:0];
    assign cout = rec_q[STAGES].carry;
    assign ovf  = rec_q[STAGES].carry ^ rec_q[STAGES].c_top;

    assign unused_tail = ^{rec_q[STAGES].a, rec_q[STAGES].b, rec_q[STAGES].sum};

endmodule
